// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : div_pkg
//  Purpose : Shared types, widths and helpers for the unsigned 16/8
//            sequential divider (unsigned_16by8_seq_div and div_step).
//  Contents: state_e FSM encoding, datapath widths, overflow predicate.
//  Revision: 1.0  initial release
// ============================================================================
package div_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int Q_W        = 8;
   localparam int CNT_W      = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // The quotient fits in Q_W bits only when the upper dividend byte is
   // strictly below the divisor; a zero divisor always fails this test.
   function automatic logic div_overflow(input logic [DIVISOR_W-1:0] dividend_hi,
                                         input logic [DIVISOR_W-1:0] divisor);
      return (divisor == '0) || (dividend_hi >= divisor);
   endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module  : div_step
//  Purpose : One combinational restoring-division step: shift the next
//            dividend bit into the partial remainder, subtract the divisor
//            when it fits, and emit the resulting quotient bit.
//  Ports   : partial_in   [8:0] partial remainder entering the step
//            divisor      [7:0] unsigned divisor
//            dividend_bit       next dividend bit (MSB first)
//            partial_out  [8:0] partial remainder leaving the step
//            q_bit              quotient bit produced by this step
//  Revision: 1.0  initial release
// ============================================================================
module div_step
   import div_pkg::*;
(
   input  logic [DIVISOR_W:0]   partial_in,
   input  logic [DIVISOR_W-1:0] divisor,
   input  logic                 dividend_bit,
   output logic [DIVISOR_W:0]   partial_out,
   output logic                 q_bit
);

   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W:0]   diff;

   always_comb begin
      // Carry one extra bit so the compare is exact for any 9-bit input.
      shifted     = {partial_in, dividend_bit};
      q_bit       = (shifted >= {2'b00, divisor});
      // When the divisor fits, the true difference is below 2*divisor and
      // therefore always representable in 9 bits.
      diff        = shifted[DIVISOR_W:0] - {1'b0, divisor};
      partial_out = q_bit ? diff : shifted[DIVISOR_W:0];
   end

endmodule : div_step
`default_nettype wire

// File: rtl/unsigned_16by8_seq_div.sv
`default_nettype none
// ============================================================================
//  Module  : unsigned_16by8_seq_div
//  Purpose : Sequential unsigned 16/8 restoring divider, one quotient bit
//            per clock, valid/ready handshake on input and output.
//  Ports   : clk, rst_n (async, active-low)
//            in_valid / in_ready      operand handshake (ready only in IDLE)
//            dividend [15:0], divisor [7:0]
//            out_valid / out_ready    result handshake (valid only in DONE)
//            quotient [7:0], remainder [7:0], ovf (div-by-zero / q > 8'hFF)
//  Macro   : DIV_APPROX_EN - stop after quotient bit APPROX_L; the low
//            APPROX_L quotient bits and the remainder are returned as zero.
//  Revision: 1.0  initial release
// ============================================================================
module unsigned_16by8_seq_div
   import div_pkg::*;
#(
   parameter int APPROX_L = 3
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [Q_W-1:0]        quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  ovf
);

`ifdef DIV_APPROX_EN
   localparam bit APPROX_ON = 1'b1;
`else
   localparam bit APPROX_ON = 1'b0;
`endif

   // Index of the last CALC step and the quotient bits that survive it.
   localparam logic [CNT_W-1:0] STOP_IDX = APPROX_ON ? CNT_W'(APPROX_L) : '0;
   localparam logic [Q_W-1:0]   Q_KEEP   = {Q_W{1'b1}} << STOP_IDX;

   state_e                 state_q,    state_d;
   logic [DIVISOR_W-1:0]   dvd_lo_q,   dvd_lo_d;
   logic [DIVISOR_W-1:0]   dvs_q,      dvs_d;
   logic [DIVISOR_W:0]     part_q,     part_d;
   logic [CNT_W-1:0]       cnt_q,      cnt_d;
   logic [Q_W-1:0]         qwork_q,    qwork_d;
   logic                   ovf_pend_q, ovf_pend_d;
   logic [Q_W-1:0]         quot_q,     quot_d;
   logic [DIVISOR_W-1:0]   rem_q,      rem_d;
   logic                   ovf_q,      ovf_d;

   logic [DIVISOR_W:0]     step_part;
   logic                   step_qbit;

   div_step u_step (
      .partial_in   (part_q),
      .divisor      (dvs_q),
      .dividend_bit (dvd_lo_q[cnt_q]),
      .partial_out  (step_part),
      .q_bit        (step_qbit)
   );

   always_comb begin
      state_d    = state_q;
      dvd_lo_d   = dvd_lo_q;
      dvs_d      = dvs_q;
      part_d     = part_q;
      cnt_d      = cnt_q;
      qwork_d    = qwork_q;
      ovf_pend_d = ovf_pend_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // The upper byte seeds the partial remainder; only the low
               // byte still has to be shifted in bit by bit.
               dvd_lo_d   = dividend[DIVISOR_W-1:0];
               dvs_d      = divisor;
               part_d     = {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
               cnt_d      = CNT_W'(Q_W - 1);
               qwork_d    = '0;
               // Overflow is resolved on the first CALC cycle so that its
               // result appears one cycle after accept.
               ovf_pend_d = div_overflow(dividend[DIVIDEND_W-1:DIVISOR_W], divisor);
               state_d    = CALC;
            end
         end

         CALC: begin
            if (ovf_pend_q) begin
               ovf_pend_d = 1'b0;
               quot_d     = {Q_W{1'b1}};
               rem_d      = {DIVISOR_W{1'b1}};
               ovf_d      = 1'b1;
               state_d    = DONE;
            end else begin
               part_d         = step_part;
               qwork_d[cnt_q] = step_qbit;
               cnt_d          = cnt_q - 1'b1;
               if (cnt_q == STOP_IDX) begin
                  quot_d  = qwork_d & Q_KEEP;
                  rem_d   = APPROX_ON ? '0 : step_part[DIVISOR_W-1:0];
                  ovf_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dvd_lo_q   <= '0;
         dvs_q      <= '0;
         part_q     <= '0;
         cnt_q      <= '0;
         qwork_q    <= '0;
         ovf_pend_q <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dvd_lo_q   <= dvd_lo_d;
         dvs_q      <= dvs_d;
         part_q     <= part_d;
         cnt_q      <= cnt_d;
         qwork_q    <= qwork_d;
         ovf_pend_q <= ovf_pend_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         ovf_q      <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign ovf       = ovf_q;

endmodule : unsigned_16by8_seq_div
`default_nettype wire

// File: tb/tb_unsigned_16by8_seq_div.sv
`default_nettype none
// ============================================================================
//  Module  : tb_unsigned_16by8_seq_div
//  Purpose : Self-checking bench for unsigned_16by8_seq_div. Expected
//            results are computed from z/y and z%y when operands are driven,
//            queued, and compared when the divider presents its result.
//  Revision: 1.0  initial release
// ============================================================================
module tb_unsigned_16by8_seq_div;

   localparam int APPROX_L = 3;
   localparam int N_RAND   = 2500;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        ovf;

   unsigned_16by8_seq_div #(.APPROX_L(APPROX_L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       ovf;
      int         acc_edge;
      int         lat;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   bit rand_rdy  = 1'b0;
   int stall_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [15:0] z, input logic [7:0] y, input int acc);
      exp_t        e;
      int unsigned qf;
      logic [7:0]  low_mask;
      e.acc_edge = acc;
      e.q   = 8'hFF;
      e.r   = 8'hFF;
      e.ovf = 1'b1;
      e.lat = 1;
      if (y != 0) begin
         qf = int'(z) / int'(y);
         if (qf <= 255) begin
            e.q   = qf[7:0];
            e.r   = 8'(int'(z) % int'(y));
            e.ovf = 1'b0;
            e.lat = 8;
`ifdef DIV_APPROX_EN
            low_mask = 8'((1 << APPROX_L) - 1);
            e.q   = e.q & ~low_mask;
            e.r   = 8'h00;
            e.lat = 8 - APPROX_L;
`else
            low_mask = 8'h00;
            e.q   = e.q & ~low_mask;
`endif
         end
      end
      return e;
   endfunction

   // ---------------------------------------------------------------------
   // Output monitor: checks results, latency, hold stability, and drives
   // out_ready for the next edge.
   // ---------------------------------------------------------------------
   exp_t       cur;
   logic       prev_v   = 1'b0;
   logic       chk_idle = 1'b0;
   logic [7:0] hold_q, hold_r;
   logic       hold_o;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v   = 1'b0;
         chk_idle = 1'b0;
      end else begin
         if (chk_idle) begin
            check_eq("idle_after_handshake", {31'd0, in_ready}, 32'd1);
            chk_idle = 1'b0;
         end
         if (out_valid) begin
            check_eq("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
            if (!prev_v) begin
               if (sb.size() == 0) begin
                  check_eq("spurious_out_valid", {31'd0, out_valid}, 32'd0);
               end else begin
                  cur = sb[0];
                  check_eq("latency",   cyc - cur.acc_edge, cur.lat);
                  check_eq("quotient",  {24'd0, quotient},  {24'd0, cur.q});
                  check_eq("remainder", {24'd0, remainder}, {24'd0, cur.r});
                  check_eq("ovf",       {31'd0, ovf},       {31'd0, cur.ovf});
               end
               hold_q = quotient;
               hold_r = remainder;
               hold_o = ovf;
            end else begin
               check_eq("hold_quotient",  {24'd0, quotient},  {24'd0, hold_q});
               check_eq("hold_remainder", {24'd0, remainder}, {24'd0, hold_r});
               check_eq("hold_ovf",       {31'd0, ovf},       {31'd0, hold_o});
            end
            if (stall_cnt > 0) begin
               out_ready = 1'b0;
               stall_cnt--;
            end else if (rand_rdy) begin
               out_ready = ($urandom_range(0, 3) != 0);
            end else begin
               out_ready = 1'b1;
            end
            if (out_ready) begin
               if (sb.size() > 0) void'(sb.pop_front());
               chk_idle = 1'b1;
            end
         end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         prev_v = out_valid;
      end
   end

   // ---------------------------------------------------------------------
   // Driver: wait for in_ready, present one operand pair for one edge, and
   // optionally wiggle in_valid/operands while the divider is busy.
   // ---------------------------------------------------------------------
   task automatic send(input logic [15:0] z, input logic [7:0] y, input bit garbage);
      int guard = 0;
      @(negedge clk);
      while (!in_ready) begin
         guard++;
         if (guard > 200) begin
            check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b1;
      dividend = z;
      divisor  = y;
      sb.push_back(model(z, y, cyc + 1));
      @(negedge clk);
      if (garbage) begin
         in_valid = 1'($urandom_range(0, 1));
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] z;
      logic [7:0]  y;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("rst_quotient",  {24'd0, quotient},  32'd0);
      check_eq("rst_remainder", {24'd0, remainder}, 32'd0);
      check_eq("rst_ovf",       {31'd0, ovf},       32'd0);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);

      // Directed cases
      send(16'h1234, 8'h56, 1'b0); drain();
      send(16'hFE01, 8'hFF, 1'b0); drain();
      send(16'h1234, 8'h00, 1'b0); drain();
      send(16'h5600, 8'h56, 1'b0); drain();
      send(16'h55FF, 8'h56, 1'b0); drain();
      send(16'h0000, 8'h01, 1'b0); drain();

      // Backpressure: result held for five cycles before release
      stall_cnt = 5;
      send(16'h0C35, 8'h2A, 1'b0); drain();

      // Reset during CALC aborts the operation
      send(16'h1234, 8'h56, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("abort_in_ready",  {31'd0, in_ready},  32'd1);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         check_eq("abort_no_pulse", {31'd0, out_valid}, 32'd0);
      end
      send(16'h0064, 8'h07, 1'b0); drain();

      // Random traffic with input gaps and output backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < N_RAND; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         y = 8'($urandom);
         if (y != 0 && $urandom_range(0, 3) != 0)
            z = 16'($urandom_range(0, int'(y) * 256 - 1));
         else
            z = 16'($urandom);
         send(z, y, 1'b1);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_unsigned_16by8_seq_div
`default_nettype wire
